// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes and FSM state encoding shared by the ALU sequencer
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/alu_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);
  logic [IDW-1:0] k;
  // scan farthest-to-nearest so the nearest requester after ptr wins
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    k = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = IDW'((int'(ptr) + i) % NREQ);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        gnt_idx = k;
      end
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one registered ALU among NREQ requesters; ALU_SEQ_OPCHK_EN enables illegal-opcode rejection
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_zero,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_sel,
  input  logic [WIDTH-1:0]      alu_r,
  input  logic                  alu_z
);
  state_t state, state_n;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gidx, ptr;
  logic [2:0] gsel;
  logic ill, take;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req_valid), .ptr(ptr), .gnt(gnt), .gnt_idx(gidx));
  assign gsel = req_sel[int'(gidx)*3 +: 3];
  assign busy = state != IDLE;
  assign take = state == IDLE && |req_valid;
`ifdef ALU_SEQ_OPCHK_EN
  assign ill = gsel > OP_SLT;
`else
  assign ill = 1'b0;
`endif
  // state register
  always_ff @(posedge CLK) state <= RST ? IDLE : state_n;
  // next state and grant strobe; grants only in IDLE and never while in reset
  always_comb begin
    req_ready = (state == IDLE && !RST) ? gnt : '0;
    state_n = state == IDLE ? (|req_valid ? (ill ? RESP : EXEC) : IDLE) :
              state == EXEC ? CAPT :
              state == CAPT ? RESP :
              (rsp_ready ? IDLE : RESP);
  end
  // operand launch on grant, result capture in CAPT, response retire in RESP
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= IDW'(NREQ - 1);
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= OP_ADD;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_id <= '0;
    end else begin
      if (take) begin
        ptr <= gidx;
        rsp_id <= gidx;
        if (ill) begin
          rsp_valid <= 1'b1;
          rsp_data <= '0;
          rsp_zero <= 1'b0;
        end else begin
          alu_a <= req_a[int'(gidx)*WIDTH +: WIDTH];
          alu_b <= req_b[int'(gidx)*WIDTH +: WIDTH];
          alu_sel <= gsel;
        end
      end
      if (state == CAPT) begin
        rsp_data <= alu_r;
        rsp_zero <= alu_z;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
`ifdef ALU_SEQ_OPCHK_EN
  // error flag follows the legality of each granted opcode
  always_ff @(posedge CLK) begin
    if (RST) rsp_err <= 1'b0;
    else if (take) rsp_err <= ill;
  end
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of the ALU sequencer against a behavioural registered ALU
module tb_alu_sequencer;
  logic CLK = 1'b0, RST = 1'b1;
  logic [1:0] req_valid = '0, req_ready;
  logic [63:0] req_a = '0, req_b = '0;
  logic [5:0] req_sel = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_data, alu_a, alu_b, alu_r = '0;
  logic rsp_id, alu_z;
  logic [2:0] alu_sel;
  int tests = 0, fails = 0;

  alu_sequencer #(.WIDTH(32), .NREQ(2)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r), .alu_z(alu_z)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK)
    alu_r <= alu_sel == 3'b001 ? (alu_a & alu_b) :
             alu_sel == 3'b010 ? (alu_a | alu_b) :
             alu_sel == 3'b011 ? alu_a * alu_b :
             alu_sel == 3'b100 ? alu_a - alu_b :
             alu_sel == 3'b101 ? {31'd0, $signed(alu_a) < $signed(alu_b)} :
             alu_a + alu_b;
  assign alu_z = alu_r == '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input int id, input logic [31:0] a, input logic [31:0] b,
                    input logic [2:0] sel, input logic [31:0] ed, input logic ez);
    int n = 0;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_sel[id*3 +: 3] = sel;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    check("op_grant", {31'd0, req_ready[id]}, 32'd1);
    @(posedge CLK); #1 req_valid[id] = 1'b0;
    @(negedge CLK);
    check("op_alu_a", alu_a, a);
    check("op_alu_b", alu_b, b);
    check("op_alu_sel", {29'd0, alu_sel}, {29'd0, sel});
    check("op_busy", {31'd0, busy}, 32'd1);
    check("op_valid_exec", {31'd0, rsp_valid}, 32'd0);
    @(negedge CLK);
    check("op_valid_capt", {31'd0, rsp_valid}, 32'd0);
    @(negedge CLK);
    check("op_valid", {31'd0, rsp_valid}, 32'd1);
    check("op_data", rsp_data, ed);
    check("op_zero", {31'd0, rsp_zero}, {31'd0, ez});
    check("op_id", {31'd0, rsp_id}, id);
    check("op_err", {31'd0, rsp_err}, 32'd0);
    @(negedge CLK);
    check("op_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int g, cyc, n;
    logic [1:0] prev;
    repeat (3) @(negedge CLK);
    req_valid = 2'b01;
    #1;
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
    check("rst_id", {31'd0, rsp_id}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    req_valid = 2'b00;
    RST = 1'b0;
    @(negedge CLK);
    op(0, 32'd5, 32'd3, 3'b000, 32'd8, 1'b0);
    op(1, 32'd7, 32'd7, 3'b100, 32'd0, 1'b1);
    op(1, 32'd2, 32'd9, 3'b101, 32'd1, 1'b0);
    op(0, 32'd6, 32'd7, 3'b011, 32'd42, 1'b0);
    op(0, 32'hC, 32'hA, 3'b001, 32'h8, 1'b0);
    op(0, 32'hFFFF_FFFF, 32'd9, 3'b101, 32'd1, 1'b0);
`ifndef ALU_SEQ_OPCHK_EN
    op(0, 32'd4, 32'd5, 3'b111, 32'd9, 1'b0);
`endif
    op(1, 32'hC, 32'hA, 3'b010, 32'hE, 1'b0);
    req_valid = 2'b11;
    g = 0;
    cyc = 0;
    prev = 2'b00;
    #1;
    while (g < 8 && cyc < 200) begin
      if (req_ready != 2'b00) begin
        check("rr_grant", {30'd0, req_ready}, (g % 2 == 0) ? 32'd1 : 32'd2);
        check("rr_gap", {30'd0, prev}, 32'd0);
        g++;
      end
      prev = req_ready;
      @(posedge CLK);
      if (g == 8) begin
        #1 req_valid = 2'b00;
      end
      @(negedge CLK); #1;
      cyc++;
    end
    check("rr_count", g, 32'd8);
    n = 0;
    while (busy && n < 20) begin
      @(negedge CLK); n++;
    end
    check("rr_drain", {31'd0, busy}, 32'd0);
    rsp_ready = 1'b0;
    req_a[31:0] = 32'd10;
    req_b[31:0] = 32'd20;
    req_sel[2:0] = 3'b000;
    req_valid = 2'b01;
    #1;
    check("bp_grant", {30'd0, req_ready}, 32'd1);
    @(posedge CLK); #1 req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge CLK); n++;
    end
    check("bp_valid_up", {31'd0, rsp_valid}, 32'd1);
    req_valid = 2'b11;
    repeat (5) begin
      @(negedge CLK); #1;
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_data", rsp_data, 32'd30);
      check("bp_hold_ready", {30'd0, req_ready}, 32'd0);
      check("bp_hold_busy", {31'd0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge CLK); #1;
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    check("bp_next_grant", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;
    @(negedge CLK);
    req_a[63:32] = 32'd1;
    req_b[63:32] = 32'd1;
    req_sel[5:3] = 3'b000;
    req_valid = 2'b10;
    #1;
    check("ab_grant", {30'd0, req_ready}, 32'd2);
    @(posedge CLK); #1 req_valid = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    check("ab_capt_busy", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    @(negedge CLK); #1;
    check("ab_valid", {31'd0, rsp_valid}, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_alu_a", alu_a, 32'd0);
    check("ab_data", rsp_data, 32'd0);
    RST = 1'b0;
    req_valid = 2'b11;
    #1;
    check("ab_first_grant", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    repeat (3) begin
      @(negedge CLK);
      check("ab_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    op(0, 32'd3, 32'd4, 3'b000, 32'd7, 1'b0);
`ifdef ALU_SEQ_OPCHK_EN
    req_sel[2:0] = 3'b111;
    req_a[31:0] = 32'd99;
    req_valid = 2'b01;
    #1;
    check("ill_grant", {30'd0, req_ready}, 32'd1);
    @(posedge CLK); #1 req_valid = 2'b00;
    @(negedge CLK);
    check("ill_valid", {31'd0, rsp_valid}, 32'd1);
    check("ill_err", {31'd0, rsp_err}, 32'd1);
    check("ill_data", rsp_data, 32'd0);
    check("ill_alu_sel", {29'd0, alu_sel}, 32'd0);
    check("ill_alu_a", alu_a, 32'd3);
    @(negedge CLK);
    check("ill_idle", {31'd0, busy}, 32'd0);
    op(1, 32'd1, 32'd2, 3'b000, 32'd3, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
